// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller.
// FSM state encodings used by interval_timer_ctrl.
package timer_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/interval_timer_ctrl_tick_prescaler.sv
// Tick prescaler: counts 0..PRESCALE-1 while enabled.
// tick_o is high on the cycle the count wraps back to zero.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick_o
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick_o = en && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_o ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: one-shot or auto-reload up-counter.
// Optional TIMER_PAUSE_EN adds a pause input that freezes timing.
module interval_timer_ctrl
  import timer_defs::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] period,
  input  logic             auto_reload,
`ifdef TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  logic [1:0]       state;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] next_count;
  logic             reload_q;
  logic             hold;
  logic             accept;
  logic             running;
  logic             wrap;

`ifdef TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign accept     = (state == ST_IDLE) && start && (period != '0);
  assign running    = (state == ST_RUN) && !hold;
  assign next_count = count + WIDTH'(1);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .en    (running),
    .tick_o(wrap)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      tick     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      period_q <= '0;
      reload_q <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            period_q <= period;
            reload_q <= auto_reload;
            count    <= '0;
          end
        end
        ST_RUN: begin
          // stop outranks a coincident terminal tick
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (wrap) begin
            tick <= 1'b1;
            if (next_count == period_q) begin
              done <= 1'b1;
              if (reload_q) begin
                count <= '0;
              end else begin
                count <= period_q;
                state <= ST_DONE;
                busy  <= 1'b0;
              end
            end else begin
              count <= next_count;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
